// File: rtl/circle_shift_pkg.sv
// Shared types and constants for the circular two-digit scroller.
package circle_shift_pkg;

    // One display digit code; values above 9 are carried through untouched.
    typedef logic [3:0] digit_t;

    // Code driven for an empty display position.
    localparam digit_t BLANK_DEFAULT = 4'hF;

    // Entries in the scroll ring: three source digits plus one blank.
    localparam int RING_LEN = 4;

    // Window position within the ring.
    typedef logic [$clog2(RING_LEN)-1:0] pos_t;

endpackage : circle_shift_pkg

// File: rtl/shift_tick_gen.sv
// Enable divider: emits a single-cycle tick on every DIV-th enabled cycle.
module shift_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    generate
        if (DIV == 1) begin : g_no_cnt
            // Every enabled cycle is a step, so no counter state exists.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign tick = enable;
        end else begin : g_cnt
            localparam int CW = $clog2(DIV);
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Next count: advance on enabled cycles, wrapping after DIV-1.
            always_comb begin
                cnt_d = cnt_q;
                if (enable) begin
                    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                end
            end

            // Count register with synchronous reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign tick = enable && (cnt_q == LAST);
        end
    endgenerate

endmodule : shift_tick_gen

// File: rtl/circle_shift.sv
// Scrolls a two-digit window circularly over [d2, d1, d0, BLANK].
module circle_shift
    import circle_shift_pkg::*;
#(
    parameter int     DIV   = 1,
    parameter digit_t BLANK = BLANK_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   enable,
    input  digit_t in_digit_2,
    input  digit_t in_digit_1,
    input  digit_t in_digit_0,
    output digit_t out_digit_1,
    output digit_t out_digit_0
);

    logic   step;
    pos_t   pos_q;
    pos_t   pos_d;
    digit_t win_1;
    digit_t win_0;
    digit_t out_1_q;
    digit_t out_0_q;

    shift_tick_gen #(
        .DIV    (DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (step)
    );

    // Window select from live inputs at the current position.
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        win_1 = BLANK;
        win_0 = BLANK;
        case (pos_q)
            2'd0: begin win_1 = in_digit_2; win_0 = in_digit_1; end
            2'd1: begin win_1 = in_digit_1; win_0 = in_digit_0; end
            2'd2: begin win_1 = in_digit_0; win_0 = BLANK;      end
            2'd3: begin win_1 = BLANK;      win_0 = in_digit_2; end
            default: ;
        endcase
    end

    // Next position: advance on a divider tick, wrapping naturally from 3 to 0.
    always_comb begin
        pos_d = step ? pos_q + 1'b1 : pos_q;
    end

    // Position and output registers; reset wins over enable.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all state updates see pre-edge values.
        if (rst) begin
            pos_q   <= '0;
            out_1_q <= BLANK;
            out_0_q <= BLANK;
        end else begin
            pos_q   <= pos_d;
            out_1_q <= win_1;
            out_0_q <= win_0;
        end
    end

    assign out_digit_1 = out_1_q;
    assign out_digit_0 = out_0_q;

endmodule : circle_shift

// File: tb/tb_circle_shift.sv
// Directed self-checking bench for circle_shift at DIV=1 and DIV=3.
module tb_circle_shift;
    import circle_shift_pkg::*;

    logic   clk = 1'b0;
    logic   rst_a, en_a, rst_b, en_b;
    digit_t d2, d1, d0;
    digit_t o1_a, o0_a, o1_b, o0_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    circle_shift #(.DIV(1)) dut_a (
        .clk         (clk),
        .rst         (rst_a),
        .enable      (en_a),
        .in_digit_2  (d2),
        .in_digit_1  (d1),
        .in_digit_0  (d0),
        .out_digit_1 (o1_a),
        .out_digit_0 (o0_a)
    );

    circle_shift #(.DIV(3)) dut_b (
        .clk         (clk),
        .rst         (rst_b),
        .enable      (en_b),
        .in_digit_2  (d2),
        .in_digit_1  (d1),
        .in_digit_0  (d0),
        .out_digit_1 (o1_b),
        .out_digit_0 (o0_b)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle past the edge before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected window pairs {out_digit_1, out_digit_0}, hand-computed.
    logic [7:0] scroll_exp [8] = '{8'h95, 8'h52, 8'h2F, 8'hF9, 8'h95, 8'h52, 8'h2F, 8'hF9};
    logic [7:0] div3_exp  [13] = '{8'h95, 8'h95, 8'h95, 8'h52, 8'h52, 8'h52,
                                   8'h2F, 8'h2F, 8'h2F, 8'hF9, 8'hF9, 8'hF9, 8'h95};

    initial begin
        d2 = 4'h9; d1 = 4'h5; d0 = 4'h2;
        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;

        // Reset held two cycles.
        tick(); check("reset_c1", {o1_a, o0_a}, 8'hFF);
        tick(); check("reset_c2", {o1_a, o0_a}, 8'hFF);
        check("reset_div3", {o1_b, o0_b}, 8'hFF);

        // First edge after release loads (d2, d1).
        rst_a = 1'b0;
        tick(); check("first_edge", {o1_a, o0_a}, 8'h95);

        // Enable low: window frozen at pos 0.
        for (int i = 0; i < 4; i++) begin
            tick(); check($sformatf("en_low_%0d", i), {o1_a, o0_a}, 8'h95);
        end

        // Scroll with period 4.
        en_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(); check($sformatf("scroll_%0d", i), {o1_a, o0_a}, scroll_exp[i]);
        end

        // Pos is now 2: dropping enable freezes the 2,F window.
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check($sformatf("hold_%0d", i), {o1_a, o0_a}, 8'h2F);
        end
        en_a = 1'b1;
        tick(); check("resume_0", {o1_a, o0_a}, 8'h2F);
        tick(); check("resume_1", {o1_a, o0_a}, 8'hF9);

        // Live-input tracking at held pos 0.
        en_a = 1'b0;
        tick(); check("live_pre", {o1_a, o0_a}, 8'h95);
        d1 = 4'h7;
        tick(); check("live_d1", {o1_a, o0_a}, 8'h97);
        d1 = 4'h5;
        tick(); check("live_restore", {o1_a, o0_a}, 8'h95);

        // Mid-operation reset at pos 2 with enable high.
        en_a = 1'b1;
        tick(); check("mid_pos0", {o1_a, o0_a}, 8'h95);
        tick(); check("mid_pos1", {o1_a, o0_a}, 8'h52);
        rst_a = 1'b1;
        tick(); check("mid_rst_0", {o1_a, o0_a}, 8'hFF);
        tick(); check("mid_rst_1", {o1_a, o0_a}, 8'hFF);
        rst_a = 1'b0;
        tick(); check("mid_restart_0", {o1_a, o0_a}, 8'h95);
        tick(); check("mid_restart_1", {o1_a, o0_a}, 8'h52);

        // Non-BCD code passes through (pos now 2).
        en_a = 1'b0;
        tick(); check("nonbcd_pre", {o1_a, o0_a}, 8'h2F);
        d0 = 4'hC;
        tick(); check("nonbcd_c", {o1_a, o0_a}, 8'hCF);
        d0 = 4'h2;

        // DIV=3: each window held exactly three cycles.
        rst_b = 1'b0; en_b = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick(); check($sformatf("div3_%0d", i), {o1_b, o0_b}, div3_exp[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_circle_shift
